// File: rtl/modmul_2957_pipe.sv
// Three-stage pipelined modular multiplier over GF(2957): product, Barrett estimate, two corrections.
// Optional range-error flag enabled by defining MODMUL_2957_RANGE_CHK_EN.
module modmul_2957_pipe #(
  parameter int Q  = 2957,
  parameter int W  = 12,
  parameter int K  = 24,
  parameter int MU = 5673
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [W-1:0] din_a,
  input  logic [W-1:0] din_b,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [W-1:0] dout_r,
  output logic         dout_err
);
  localparam int PW = 2 * W;
  localparam int MW = PW + 13;
  localparam logic [W+1:0] QR = (W+2)'(Q);

  logic          adv;
  logic [2:0]    vld_q;
  logic [PW-1:0] p1_q, p1_d, p2_q;
  logic [W:0]    t2_q, t2_d;
  logic [PW-1:0] tq;
  logic [W+1:0]  r0, r1, r2;
  logic [W-1:0]  r_q;

  // One global enable: every stage moves together, so only the output slot can hold a stall.
  assign adv       = ~vld_q[2] | dout_ready;
  assign din_ready = adv;

  assign p1_d = PW'(din_a) * PW'(din_b);
  assign t2_d = (W+1)'((MW'(p1_q) * MW'(MU)) >> K);

  // The estimate t never exceeds p/Q, so the difference is below 3Q and non-negative.
  assign tq = PW'(t2_q) * PW'(Q);
  assign r0 = (W+2)'(p2_q - tq);
  assign r1 = (r0 >= QR) ? r0 - QR : r0;
  assign r2 = (r1 >= QR) ? r1 - QR : r1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      t2_q  <= '0;
      r_q   <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[1:0], din_valid};
      p1_q  <= p1_d;
      p2_q  <= p1_q;
      t2_q  <= t2_d;
      r_q   <= r2[W-1:0];
    end
  end

  assign dout_valid = vld_q[2];
  assign dout_r     = r_q;

`ifdef MODMUL_2957_RANGE_CHK_EN
  localparam logic [W-1:0] QW = W'(Q);
  logic e1_q, e2_q, e3_q;

  // The last stage gates with the valid bit so the flag is never seen on an empty slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_q <= 1'b0;
      e2_q <= 1'b0;
      e3_q <= 1'b0;
    end else if (adv) begin
      e1_q <= (din_a >= QW) | (din_b >= QW);
      e2_q <= e1_q;
      e3_q <= e2_q & vld_q[1];
    end
  end

  assign dout_err = e3_q;
`else
  assign dout_err = 1'b0;
`endif

endmodule

// File: doc/modmul_2957_pipe.md
Name: modmul_2957_pipe

Overview:
- Pipelined modular multiplier over GF(2957) that produces residues.
- Accepts two 12-bit residues, forms their 24-bit product, and reduces it with a Barrett estimate plus correction, all internally.
- It is the producer-side counterpart to the standalone combinational Barrett reducer: it generates the wide operand and returns the reduced result.
- Sits in the arithmetic datapath behind a valid/ready stream, e.g. NTT butterflies or polynomial multiply.

Parameters:
- Q, 2957, prime modulus.
- W, 12, residue width; requires Q < 2^W.
- K, 24, Barrett shift; K = 2*W.
- MU, 5673, floor(2^K / Q); must be consistent with Q and K.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din_valid  in  1  operand pair valid.
- din_ready  out  1  block can accept an operand pair this cycle.
- din_a  in  W  operand a; legal range 0..Q-1.
- din_b  in  W  operand b; legal range 0..Q-1.
- dout_valid  out  1  result valid.
- dout_ready  in  1  downstream accepts the result.
- dout_r  out  W  (din_a*din_b) mod Q.
- dout_err  out  1  range-error flag (see Optional Feature).

Behaviour:
- Reset: one clock domain. Asserting rst_n low asynchronously clears all stage valid bits, dout_valid, dout_r and dout_err to 0. Data registers reset to 0.
- Handshake: transfer in when din_valid & din_ready; transfer out when dout_valid & dout_ready.
  - Payload stays stable while valid is high and ready is low.
- Pipeline: three stages under one global advance enable, adv = ~dout_valid | dout_ready. din_ready = adv, combinational.
  - S1: p = din_a*din_b, 2W bits, registered with valid bit v1.
  - S2: t = (p*MU) >> K, registered along with p; valid bit v2.
  - S3: r0 = p - t*Q, where r0 < 3Q and is held in W+2 bits. r1 = r0>=Q ? r0-Q : r0. r2 = r1>=Q ? r1-Q : r1. dout_r <= r2[W-1:0], dout_valid <= v2.
- Latency: an accepted pair appears on dout_r exactly 3 cycles later when dout_ready stays high.
- Throughput: 1 result per cycle.
- Bubbles: bubbles propagate as invalid slots and are never emitted. A stage advances when adv=1 regardless of its own valid bit, so bubbles collapse under stall only at the output.
- Stall: with dout_ready=0 and dout_valid=1, all stages freeze and din_ready=0. No result is dropped or duplicated.
- Ordering: strict FIFO; results leave in acceptance order.
- Arithmetic: all intermediate widths are unsigned and sized to the maximum value. p*MU fits in 2W+13 bits. t*Q <= p, so r0 never goes negative.
- Boundaries:
  - Operands 0 give result 0.
  - (Q-1)*(Q-1) gives 1.
  - The maximum estimate error is two corrections, and both are always implemented.
- Reset mid-operation: in-flight operations are discarded. The first cycle after release shows din_ready=1 and dout_valid=0.

Optional Feature:
- Macro: MODMUL_2957_RANGE_CHK_EN.
- Defined:
  - S1 also registers e1 = (din_a>=Q)|(din_b>=Q), carried down the pipeline alongside the data.
  - dout_err equals the carried flag, aligned with dout_valid. It is 0 when dout_valid=0.
  - dout_r for a flagged item is still computed as (a*b) mod Q.
- Undefined: dout_err is tied to 0, with no extra flops.
- In both cases dout_r for legal operands is identical.

Test Plan:
- rst_n low then high, then din_a=2956, din_b=2956, dout_ready=1 -> dout_valid rises on the 3rd cycle after acceptance, dout_r=1.
- Back-to-back stream (1000,3), (2956,2), (0,1234), (1,2956) -> dout_r=43, 2955, 0, 2956 on consecutive cycles, in order.
- Stream 8 random legal pairs, with dout_ready low for cycles 4-8 -> din_ready low during the stall, dout_r held stable, all 8 results correct against a reference a*b%2957, none lost or duplicated.
- Exhaustive sweep: a=0..2956 with b=2956, plus a=b=0..2956 -> every dout_r == a*b%2957, logged EQUAL/ERROR per item.
- rst_n pulsed low for 1 cycle while 3 items are in flight -> dout_valid drops to 0 immediately with no stale output afterwards; the next pair (5,7) returns 35.
- With MODMUL_2957_RANGE_CHK_EN: (3000,1) -> dout_err=1 with dout_r=43; then (2,3) -> dout_err=0 with dout_r=6. Without the macro -> dout_err is 0 for both.
